// File: rtl/udp_pkg.sv
// udp_pkg: shared FSM encoding and length width for the UDP word serializer.
package udp_pkg;
    localparam int LEN_W = 16;
    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;
endpackage

// File: rtl/udp_byte_mux.sv
// udp_byte_mux: combinational pick of payload byte idx_i from a word, in MSB- or LSB-first order.
module udp_byte_mux
    import udp_pkg::*;
#(
    parameter int DATA_W    = 960,
    parameter int MSB_FIRST = 1
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [LEN_W-1:0]  idx_i,
    output logic [7:0]        byte_o
);
    localparam logic [LEN_W-1:0] BYTES = LEN_W'(DATA_W / 8);
    logic [LEN_W-1:0]  pos;
    logic [DATA_W-1:0] shifted;
    assign pos     = (MSB_FIRST != 0) ? BYTES - LEN_W'(1) - idx_i : idx_i;
    assign shifted = word_i >> {pos, 3'b000};
    assign byte_o  = shifted[7:0];
endmodule

// File: rtl/udp_word_serializer.sv
// udp_word_serializer: latches one wide payload word and streams it out a byte per handshake,
// zero-padding short frames up to MIN_LEN.
module udp_word_serializer
    import udp_pkg::*;
#(
    parameter int DATA_W    = 960,
    parameter int MSB_FIRST = 1,
    parameter int MIN_LEN   = 18
) (
    input  logic              rgmii_clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_length,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_length,
    output logic              len_err
);
    localparam logic [LEN_W-1:0] BYTES = LEN_W'(DATA_W / 8);
    localparam logic [LEN_W-1:0] MIN   = LEN_W'(MIN_LEN);
    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q, olen_q, cnt_q, cnt_d, eff_len, frame_len;
    logic              valid_q, last_q, err_q, accept, fire;
    logic [7:0]        mux_byte;
    udp_byte_mux #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_mux (
        .word_i(data_q),
        .idx_i (cnt_q),
        .byte_o(mux_byte)
    );
    assign in_ready   = state_q == IDLE;
    assign accept     = in_valid & in_ready;
    assign fire       = valid_q & out_ready;
    assign eff_len    = in_length > BYTES ? BYTES : in_length;
    assign frame_len  = eff_len > MIN ? eff_len : MIN;
    assign cnt_d      = cnt_q + LEN_W'(1);
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign out_length = olen_q;
    assign len_err    = err_q;
    assign out_data   = state_q == SEND ? mux_byte : 8'h00;
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            olen_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && (in_length == '0 || in_length > BYTES);
            case (state_q)
                IDLE: if (accept && in_length != '0) begin
                    data_q  <= in_data;
                    len_q   <= eff_len;
                    olen_q  <= frame_len;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    last_q  <= frame_len == LEN_W'(1);
                    state_q <= SEND;
                end
                default: if (fire) begin
                    if (last_q) begin
                        // Leaving through IDLE keeps in_ready low on the last handshake cycle.
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                        last_q  <= cnt_d == olen_q - LEN_W'(1);
                        state_q <= cnt_d >= len_q ? PAD : SEND;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_word_serializer.sv
// tb_udp_word_serializer: scoreboard bench over three parameterisations of the serializer.
module tb_udp_word_serializer;
    typedef struct packed {
        logic [7:0]  d;
        logic        last;
        logic [15:0] olen;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic iv_a = 1'b0, ordy_a = 1'b1, rdy_a, ovld_a, ol_a, le_a;
    logic [31:0] din_a = '0;
    logic [15:0] len_a = '0, olen_a;
    logic [7:0] od_a;
    logic iv_b = 1'b0, ordy_b = 1'b1, rdy_b, ovld_b, ol_b, le_b;
    logic [31:0] din_b = '0;
    logic [15:0] len_b = '0, olen_b;
    logic [7:0] od_b;
    logic iv_c = 1'b0, ordy_c = 1'b1, rdy_c, ovld_c, ol_c, le_c;
    logic [959:0] din_c = '0;
    logic [15:0] len_c = '0, olen_c;
    logic [7:0] od_c;
    udp_word_serializer #(.DATA_W(32), .MSB_FIRST(1), .MIN_LEN(0)) u_a (
        .rgmii_clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a), .in_data(din_a),
        .in_length(len_a), .out_valid(ovld_a), .out_ready(ordy_a), .out_data(od_a),
        .out_last(ol_a), .out_length(olen_a), .len_err(le_a));
    udp_word_serializer #(.DATA_W(32), .MSB_FIRST(0), .MIN_LEN(0)) u_b (
        .rgmii_clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b), .in_data(din_b),
        .in_length(len_b), .out_valid(ovld_b), .out_ready(ordy_b), .out_data(od_b),
        .out_last(ol_b), .out_length(olen_b), .len_err(le_b));
    udp_word_serializer #(.DATA_W(960), .MSB_FIRST(1), .MIN_LEN(18)) u_c (
        .rgmii_clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(rdy_c), .in_data(din_c),
        .in_length(len_c), .out_valid(ovld_c), .out_ready(ordy_c), .out_data(od_c),
        .out_last(ol_c), .out_length(olen_c), .len_err(le_c));
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    int total = 0, bad = 0;
    logic tog_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    int k = 0;
    logic stall_a = 1'b0;
    logic [9:0] held_a = '0;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic rdy(int i);
        return i == 0 ? rdy_a : i == 1 ? rdy_b : rdy_c;
    endfunction
    function automatic logic ovld(int i);
        return i == 0 ? ovld_a : i == 1 ? ovld_b : ovld_c;
    endfunction
    function automatic logic le(int i);
        return i == 0 ? le_a : i == 1 ? le_b : le_c;
    endfunction
    function automatic int qsize(int i);
        return i == 0 ? qa.size() : i == 1 ? qb.size() : qc.size();
    endfunction
    // Reference model: byte order, clamp, padding and last flag derived from the parameters.
    task automatic model(int i, logic [959:0] d, int len);
        int bw, msb, mn, l, ol;
        exp_t e;
        bw  = i == 2 ? 120 : 4;
        msb = i == 1 ? 0 : 1;
        mn  = i == 2 ? 18 : 0;
        if (len == 0) return;
        l  = len > bw ? bw : len;
        ol = l > mn ? l : mn;
        for (int j = 0; j < ol; j++) begin
            e.d    = j >= l ? 8'h00 : d[8 * (msb != 0 ? bw - 1 - j : j) +: 8];
            e.last = j == ol - 1;
            e.olen = 16'(ol);
            if (i == 0) qa.push_back(e);
            else if (i == 1) qb.push_back(e);
            else qc.push_back(e);
        end
    endtask
    task automatic send(int i, logic [959:0] d, int len, logic exp_err);
        int n = 0;
        case (i)
            0: begin iv_a = 1'b1; din_a = d[31:0]; len_a = 16'(len); end
            1: begin iv_b = 1'b1; din_b = d[31:0]; len_b = 16'(len); end
            default: begin iv_c = 1'b1; din_c = d; len_c = 16'(len); end
        endcase
        while (!rdy(i) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 32'(n < 500), 1);
        model(i, d, len);
        @(posedge clk); #1;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        chk("len_err", le(i), exp_err);
        chk("valid_lat1", ovld(i), 32'(len != 0));
        if (len == 0) chk("ready_stays", rdy(i), 1);
        @(posedge clk); #1;
        chk("len_err_pulse", le(i), 0);
    endtask
    task automatic wait_idle(int i, int exp_n);
        int n = 1;
        while (!rdy(i) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_wait", 32'(n < 1000), 1);
        if (exp_n > 0) chk("frame_cycles", n, exp_n);
        chk("q_empty", qsize(i), 0);
    endtask
    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            ordy_a = pat[k];
            k = (k + 1) % 4;
        end else ordy_a = 1'b1;
    end
    always @(negedge clk) if (!rst) begin
        if (stall_a) chk("a_hold", {ovld_a, ol_a, od_a}, held_a);
        stall_a = ovld_a && !ordy_a;
        held_a  = {ovld_a, ol_a, od_a};
        if (ovld_a && ordy_a) begin
            if (qa.size() == 0) chk("a_extra_byte", 32'(qa.size()), 1);
            else begin
                ea = qa.pop_front();
                chk("a_data", od_a, ea.d);
                chk("a_last", ol_a, ea.last);
                chk("a_olen", olen_a, ea.olen);
            end
        end
    end
    always @(negedge clk) if (!rst && ovld_b && ordy_b) begin
        if (qb.size() == 0) chk("b_extra_byte", 32'(qb.size()), 1);
        else begin
            eb = qb.pop_front();
            chk("b_data", od_b, eb.d);
            chk("b_last", ol_b, eb.last);
            chk("b_olen", olen_b, eb.olen);
        end
    end
    always @(negedge clk) if (!rst && ovld_c && ordy_c) begin
        if (qc.size() == 0) chk("c_extra_byte", 32'(qc.size()), 1);
        else begin
            ec = qc.pop_front();
            chk("c_data", od_c, ec.d);
            chk("c_last", ol_c, ec.last);
            chk("c_olen", olen_c, ec.olen);
        end
    end
    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
    initial begin
        logic [959:0] d;
        int n;
        for (int j = 0; j < 30; j++) d[32 * j +: 32] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", ovld_a, 0);
        chk("rst_last_a", ol_a, 0);
        chk("rst_data_a", od_a, 0);
        chk("rst_olen_a", olen_a, 0);
        chk("rst_err_a", le_a, 0);
        chk("rst_valid_c", ovld_c, 0);
        chk("rst_last_c", ol_c, 0);
        chk("rst_olen_c", olen_c, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst_a", rdy_a, 1);
        chk("ready_after_rst_b", rdy_b, 1);
        chk("ready_after_rst_c", rdy_c, 1);
        send(0, 960'hA1B2C3D4, 4, 1'b0);
        wait_idle(0, 4);
        send(1, 960'hA1B2C3D4, 4, 1'b0);
        wait_idle(1, 4);
        send(2, d, 3, 1'b0);
        wait_idle(2, 18);
        send(2, d, 200, 1'b1);
        wait_idle(2, 120);
        send(2, d, 0, 1'b1);
        chk("len0_no_valid", ovld_c, 0);
        send(2, ~d, 120, 1'b0);
        wait_idle(2, 120);
        send(2, d, 18, 1'b0);
        wait_idle(2, 18);
        send(0, {928'd0, d[63:32]}, 2, 1'b0);
        wait_idle(0, 2);
        send(1, {928'd0, d[95:64]}, 5, 1'b1);
        wait_idle(1, 4);
        tog_en = 1'b1;
        send(0, 960'h11223344, 4, 1'b0);
        wait_idle(0, 0);
        send(0, {928'd0, d[127:96]}, 3, 1'b0);
        wait_idle(0, 0);
        tog_en = 1'b0;
        send(2, d, 10, 1'b0);
        n = 0;
        while (qc.size() > 13 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_wait", 32'(n < 100), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", ovld_c, 0);
        chk("abort_last", ol_c, 0);
        qc.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", rdy_c, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_resume", ovld_c, 0);
        send(2, ~d, 3, 1'b0);
        wait_idle(2, 18);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/udp_word_serializer.md
UDP_WORD_SERIALIZER -- requirements
Module: udp_word_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 960, meaning input word width in bits; multiple of 8, range 8..2048.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends byte [DATA_W-1:DATA_W-8] first; 0 sends byte [7:0] first.
REQ-003 SHALL have parameter MIN_LEN, default 18, meaning minimum emitted payload in bytes; shorter frames are zero-padded; 0 disables padding.
REQ-004 SHALL have port rgmii_clk  in  1  sole clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  word offered.
REQ-007 SHALL have port in_ready  out  1  word accepted when in_valid & in_ready.
REQ-008 SHALL have port in_data  in  DATA_W  payload word.
REQ-009 SHALL have port in_length  in  16  valid payload bytes in in_data.
REQ-010 SHALL have port out_valid  out  1  byte valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts byte.
REQ-012 SHALL have port out_data  out  8  payload byte.
REQ-013 SHALL have port out_last  out  1  final byte of frame, qualified by out_valid.
REQ-014 SHALL have port out_length  out  16  emitted frame length in bytes, stable from first byte to last.
REQ-015 SHALL have port len_err  out  1  one-cycle pulse on acceptance of an illegal length.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, PAD.
REQ-017 SHALL assert in_ready only in IDLE; out_valid SHALL be 0 in IDLE.
REQ-018 SHALL, on acceptance in IDLE, register in_data and the effective length L, enter SEND, and present the first byte with out_valid=1 on the next cycle (latency 1).
REQ-019 SHALL set L = DATA_W/8 and pulse len_err when in_length > DATA_W/8.
REQ-020 SHALL, when in_length = 0, pulse len_err, emit nothing, and stay in IDLE.
REQ-021 SHALL set out_length = max(L, MIN_LEN), computed in 16-bit arithmetic.
REQ-022 SHALL hold out_data, out_last and out_valid stable while out_valid & ~out_ready.
REQ-023 SHALL advance one byte per cycle in which out_valid & out_ready is true; a byte counter SHALL count from 0 to out_length-1 with no wrap.
REQ-024 SHALL, in SEND, emit bytes 0..L-1 in MSB_FIRST order.
REQ-025 SHALL move from SEND to PAD after byte L-1 when L < MIN_LEN; PAD SHALL emit 0x00 until out_length bytes are sent.
REQ-026 SHALL assert out_last on byte out_length-1 only, and return to IDLE on its handshake.
REQ-027 SHALL NOT assert in_ready in the cycle in which the last byte handshakes; the earliest next acceptance is the following cycle, a 1-cycle bubble.
REQ-028 SHALL accept the L = 1, MIN_LEN = 0 case with out_last set on the first byte.

Reset
REQ-029 SHALL, while rst=1 at a rgmii_clk edge, enter IDLE and clear out_valid, out_last and len_err to 0; out_data and out_length SHALL reset to 0; the counter SHALL reset to 0.
REQ-030 SHALL abort a frame if rst asserts mid-frame: no out_last is emitted, and the aborted frame SHALL NOT resume.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place FSM state encoding and the length width constant (16) in shared package udp_pkg.
REQ-033 SHALL use one sub-module, udp_byte_mux, that selects byte index i from the DATA_W register per MSB_FIRST; this sub-module SHALL be combinational.
REQ-034 SHALL use flop-based storage only: one DATA_W register, with no RAM or FIFO.

Verification
REQ-035 Bench SHALL cover: DATA_W=32, MSB_FIRST=1, MIN_LEN=0, data 0xA1B2C3D4, length 4, out_ready=1 -> A1,B2,C3,D4 on consecutive cycles, out_last on D4, out_length=4.
REQ-036 Bench SHALL cover: same stimulus with MSB_FIRST=0 -> D4,C3,B2,A1.
REQ-037 Bench SHALL cover: DATA_W=960, MIN_LEN=18, length 3 -> 3 data bytes then 15 bytes of 0x00, out_length=18, out_last on byte 18.
REQ-038 Bench SHALL cover: length 200 with DATA_W=960 -> len_err pulse, 120 bytes emitted; length 0 -> len_err pulse, no output, in_ready stays 1.
REQ-039 Bench SHALL cover: out_ready toggling 1,0,0,1 during a frame -> out_data held during stalls, no byte lost or duplicated.
REQ-040 Bench SHALL cover: rst pulse at byte 5 of 10 -> out_valid=0 next cycle, no out_last, in_ready=1 after release.
